// File: rtl/alu_stage.sv
// Registered Hack ALU pipeline stage with valid/ready handshake and optional skid entry.
// Optional carry/overflow status outputs are enabled by defining ALU_STATUS_EN.

module not16 (
    input  logic [15:0] in,
    output logic [15:0] out
);
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bit
            assign out[gi] = ~in[gi];
        end
    endgenerate
endmodule

module alu_stage #(
    parameter int WIDTH = 16,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
`ifdef ALU_STATUS_EN
    ,
    output logic             cf,
    output logic             vf
`endif
);

`ifdef ALU_STATUS_EN
    localparam int SW = 2;
`else
    localparam int SW = 0;
`endif
    // Result bundle layout: {status, zr, ng, out}
    localparam int RW = WIDTH + 2 + SW;

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    logic zx_c, nx_c, zy_c, ny_c, f_c, no_c;
    logic [WIDTH-1:0] xa, xa_n, xb, ya, ya_n, yb;
    logic [WIDTH-1:0] sum, r, r_n, out_c;
    logic [RW-1:0]    res;

    state_t        state_reg, state_next;
    logic [RW-1:0] out_reg, out_next;
    logic [RW-1:0] skid_reg, skid_next;
    logic          in_fire, out_fire;

    assign {zx_c, nx_c, zy_c, ny_c, f_c, no_c} = ctrl;

    assign xa = zx_c ? '0 : x;
    assign ya = zy_c ? '0 : y;

    generate
        if (WIDTH == 16) begin : g_not16
            not16 u_nx (.in(xa), .out(xa_n));
            not16 u_ny (.in(ya), .out(ya_n));
            not16 u_no (.in(r),  .out(r_n));
        end else begin : g_inv
            assign xa_n = ~xa;
            assign ya_n = ~ya;
            assign r_n  = ~r;
        end
    endgenerate

    assign xb    = nx_c ? xa_n : xa;
    assign yb    = ny_c ? ya_n : ya;
    assign r     = f_c ? sum : (xb & yb);
    assign out_c = no_c ? r_n : r;

`ifdef ALU_STATUS_EN
    logic [WIDTH:0] sum_ext;
    logic           cf_c, vf_c;
    assign sum_ext = {1'b0, xb} + {1'b0, yb};
    assign sum     = sum_ext[WIDTH-1:0];
    // Status reflects the adder itself, independent of the final inversion
    assign cf_c    = f_c & sum_ext[WIDTH];
    assign vf_c    = f_c & (xb[WIDTH-1] == yb[WIDTH-1]) & (sum[WIDTH-1] != xb[WIDTH-1]);
    assign res     = {cf_c, vf_c, (out_c == '0), out_c[WIDTH-1], out_c};
    assign {cf, vf, zr, ng, out} = out_reg;
`else
    assign sum = xb + yb;
    assign res = {(out_c == '0), out_c[WIDTH-1], out_c};
    assign {zr, ng, out} = out_reg;
`endif

    assign out_valid = (state_reg != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_next = state_reg;
        out_next   = out_reg;
        skid_next  = skid_reg;
        case (state_reg)
            EMPTY: begin
                if (in_fire) begin
                    state_next = BUSY;
                    out_next   = res;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    out_next = res;
                end else if (in_fire) begin
                    state_next = FULL;
                    skid_next  = res;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_next = BUSY;
                    out_next   = skid_reg;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
            out_reg   <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            skid_reg  <= skid_next;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    in_ready_reg <= 1'b0;
                end else begin
                    in_ready_reg <= (state_next != FULL);
                end
            end
            assign in_ready = in_ready_reg;
        end else begin : g_noskid
            // Without the skid entry, acceptance in BUSY relies on the consumer draining this cycle
            assign in_ready = !reset && (!out_valid || out_ready);
        end
    endgenerate

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: directed Hack ALU cases, backpressure, reset, and
// randomized traffic against an occupancy/FIFO reference model.

module tb_alu_stage;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x, y;
    logic [5:0]    ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out;
    logic          zr, ng;
`ifdef ALU_STATUS_EN
    logic          cf, vf;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct packed {
        logic [W-1:0] o;
        logic         zr;
        logic         ng;
        logic         cf;
        logic         vf;
    } exp_t;

    exp_t exp_q[$];

    alu_stage #(.WIDTH(W), .SKID(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zr(zr), .ng(ng)
`ifdef ALU_STATUS_EN
        , .cf(cf), .vf(vf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: Hack ALU rules in plain integer arithmetic
    function automatic exp_t model(input int unsigned xv, input int unsigned yv, input logic [5:0] c);
        exp_t e;
        int unsigned xa, xb, ya, yb, rr, s, ov;
        int sx, sy, ss;
        xa = c[5] ? 0 : xv;
        xb = c[4] ? (65535 - xa) : xa;
        ya = c[3] ? 0 : yv;
        yb = c[2] ? (65535 - ya) : ya;
        e.cf = 1'b0;
        e.vf = 1'b0;
        if (c[1]) begin
            s  = xb + yb;
            rr = s % 65536;
            sx = (xb >= 32768) ? int'(xb) - 65536 : int'(xb);
            sy = (yb >= 32768) ? int'(yb) - 65536 : int'(yb);
            ss = sx + sy;
            e.cf = (s >= 65536);
            e.vf = (ss > 32767) || (ss < -32768);
        end else begin
            rr = xb & yb;
        end
        ov   = c[0] ? (65535 - rr) : rr;
        e.o  = ov[W-1:0];
        e.zr = (ov == 0);
        e.ng = (ov >= 32768);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // One handshake cycle: check occupancy-derived flags, score any output, log any input, advance
    task automatic cyc();
        exp_t e;
        chk("out_valid_vs_occupancy", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("in_ready_vs_occupancy", 32'(in_ready), 32'(exp_q.size() < 2));
        if (out_valid && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_data", 32'(out), 32'(e.o));
            chk("out_zr", 32'(zr), 32'(e.zr));
            chk("out_ng", 32'(ng), 32'(e.ng));
`ifdef ALU_STATUS_EN
            chk("out_cf", 32'(cf), 32'(e.cf));
            chk("out_vf", 32'(vf), 32'(e.vf));
`endif
            $display("out  %h zr=%0d ng=%0d", out, zr, ng);
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(x, y, ctrl));
            $display("in   x=%h y=%h ctrl=%b", x, y, ctrl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            cyc();
            budget++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_zr_ng", 32'({zr, ng}), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [5:0] cst [3];
        logic [W-1:0] cst_out [3];
        logic [W-1:0] held;
        int budget;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; ctrl = '0;
        do_reset();

        // x + y
        out_ready = 1'b1;
        x = 16'd5; y = 16'd7; ctrl = 6'b000010; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_out", 32'(out), 32'h000C);
        chk("add_flags", 32'({zr, ng}), 32'd0);
        cyc();
        chk("add_valid_one_cycle", 32'(out_valid), 32'd0);

        // Constant functions, random operands
        cst[0] = 6'b101010; cst_out[0] = 16'h0000;
        cst[1] = 6'b111111; cst_out[1] = 16'h0001;
        cst[2] = 6'b111010; cst_out[2] = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            x = W'($urandom); y = W'($urandom); ctrl = cst[i]; in_valid = 1'b1;
            cyc();
            in_valid = 1'b0;
            chk("const_out", 32'(out), 32'(cst_out[i]));
            chk("const_zr", 32'(zr), 32'(i == 0));
            chk("const_ng", 32'(ng), 32'(i == 2));
            cyc();
        end

        // x - y and y - x
        x = 16'd3; y = 16'd5; ctrl = 6'b010011; in_valid = 1'b1;
        cyc();
        chk("x_minus_y", 32'(out), 32'hFFFE);
        chk("x_minus_y_ng", 32'(ng), 32'd1);
        ctrl = 6'b000111;
        cyc();
        in_valid = 1'b0;
        chk("y_minus_x", 32'(out), 32'h0002);
        cyc();

        // Backpressure: two accepted, third held, ordered drain
        out_ready = 1'b0; ctrl = 6'b000010; in_valid = 1'b1;
        x = 16'd1; y = 16'd1; cyc();
        x = 16'd2; y = 16'd2; cyc();
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        x = 16'd3; y = 16'd3;
        held = out;
        repeat (3) cyc();
        chk("bp_stall_stable", 32'(out), 32'(held));
        chk("bp_stall_value", 32'(out), 32'h0002);
        out_ready = 1'b1;
        budget = 0;
        while (budget < 10) begin
            if (in_ready) begin
                cyc();
                break;
            end
            cyc();
            budget++;
        end
        chk("bp_third_accept_timeout", 32'(budget < 10), 32'd1);
        drain();

        // Reset while FULL
        out_ready = 1'b0; in_valid = 1'b1; ctrl = 6'b000010;
        x = 16'd9; y = 16'd9; cyc();
        x = 16'd4; y = 16'd4; cyc();
        chk("full_before_reset", 32'(in_ready), 32'd0);
        do_reset();

`ifdef ALU_STATUS_EN
        out_ready = 1'b1; ctrl = 6'b000010; in_valid = 1'b1;
        x = 16'h7FFF; y = 16'h0001; cyc();
        chk("st_ovf_out", 32'(out), 32'h8000);
        chk("st_ovf_flags", 32'({cf, vf, ng}), 32'b011);
        x = 16'hFFFF; y = 16'h0001; cyc();
        in_valid = 1'b0;
        chk("st_carry_out", 32'(out), 32'h0000);
        chk("st_carry_flags", 32'({cf, vf, zr}), 32'b101);
        cyc();
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            x    = W'($urandom);
            y    = W'($urandom);
            ctrl = 6'($urandom);
            cyc();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
